// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl: multi-cycle MIPS-style control FSM with retired-instruction counter.
// Ports:
//   CLK      - clock, all state updates on its rising edge
//   RST      - asynchronous active-high reset
//   Op       - opcode (instruction bits [31:26])
//   MRdy     - shared memory has completed the current access
//   PCWr, PCWrCond, IorD, MRead, MWrite, IRWr, MtoR, RegDs, Rw, ALUsrcA - datapath strobes/selects
//   ALUsrcB  - 00 rd2, 01 const 4, 10 sign-ext imm, 11 shifted imm
//   AOp      - 000 add, 001 sub, 010 decode funct
//   PCSrc    - 00 ALU result, 01 ALU out register, 10 jump target
//   State    - current state code
//   Err      - sticky illegal-opcode flag
//   InsCnt   - retired-instruction counter, wraps silently
module multi_cycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [5:0]       Op,
  input  logic             MRdy,
  output logic             PCWr,
  output logic             PCWrCond,
  output logic             IorD,
  output logic             MRead,
  output logic             MWrite,
  output logic             IRWr,
  output logic             MtoR,
  output logic             RegDs,
  output logic             Rw,
  output logic             ALUsrcA,
  output logic [1:0]       ALUsrcB,
  output logic [2:0]       AOp,
  output logic [1:0]       PCSrc,
  output logic [3:0]       State,
  output logic             Err,
  output logic [CNT_W-1:0] InsCnt
);
  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MADDR  = 4'd2,
    MRD    = 4'd3,
    MWB    = 4'd4,
    MWR    = 4'd5,
    REXE   = 4'd6,
    RWB    = 4'd7,
    BEQ    = 4'd8,
    JMP    = 4'd9,
    IEXE   = 4'd10,
    IWB    = 4'd11,
    ERR    = 4'd15
  } state_t;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  state_t state, next;
  logic   retire;
  // An instruction retires when a final state hands control back to FETCH;
  // FETCH holding on itself is a stall, not a retirement.
  assign retire = (next == FETCH) &&
                  (state inside {MWB, MWR, RWB, IWB, BEQ, JMP});
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= FETCH;
      InsCnt <= '0;
    end else begin
      state <= next;
      if (retire) InsCnt <= InsCnt + 1'b1;
    end
  end
  assign State = state;
  assign Err   = (state == ERR);
  always_comb begin
    next     = state;
    PCWr     = 1'b0;
    PCWrCond = 1'b0;
    IorD     = 1'b0;
    MRead    = 1'b0;
    MWrite   = 1'b0;
    IRWr     = 1'b0;
    MtoR     = 1'b0;
    RegDs    = 1'b0;
    Rw       = 1'b0;
    ALUsrcA  = 1'b0;
    ALUsrcB  = 2'b00;
    AOp      = 3'b000;
    PCSrc    = 2'b00;
    case (state)
      FETCH: begin
        MRead   = 1'b1;
        ALUsrcB = 2'b01;
        // IR load and PC+4 only commit on the cycle memory delivers the word
        IRWr    = MRdy;
        PCWr    = MRdy;
        next    = MRdy ? DECODE : FETCH;
      end
      DECODE: begin
        ALUsrcB = 2'b11;
        case (Op)
          OP_R:         next = REXE;
          OP_LW, OP_SW: next = MADDR;
          OP_BEQ:       next = BEQ;
          OP_J:         next = JMP;
          OP_ADDI:      next = IEXE;
          default:      next = ERR;
        endcase
      end
      MADDR: begin
        ALUsrcA = 1'b1;
        ALUsrcB = 2'b10;
        next    = (Op == OP_LW) ? MRD : MWR;
      end
      MRD: begin
        MRead = 1'b1;
        IorD  = 1'b1;
        next  = MRdy ? MWB : MRD;
      end
      MWB: begin
        Rw   = 1'b1;
        MtoR = 1'b1;
        next = FETCH;
      end
      MWR: begin
        IorD   = 1'b1;
        MWrite = MRdy;
        next   = MRdy ? FETCH : MWR;
      end
      REXE: begin
        ALUsrcA = 1'b1;
        AOp     = 3'b010;
        next    = RWB;
      end
      RWB: begin
        Rw    = 1'b1;
        RegDs = 1'b1;
        next  = FETCH;
      end
      BEQ: begin
        ALUsrcA  = 1'b1;
        AOp      = 3'b001;
        PCWrCond = 1'b1;
        PCSrc    = 2'b01;
        next     = FETCH;
      end
      JMP: begin
        PCWr  = 1'b1;
        PCSrc = 2'b10;
        next  = FETCH;
      end
      IEXE: begin
        ALUsrcA = 1'b1;
        ALUsrcB = 2'b10;
        next    = IWB;
      end
      IWB: begin
        Rw   = 1'b1;
        next = FETCH;
      end
      ERR:     next = ERR;
      // unused encodings fall into the sticky error state
      default: next = ERR;
    endcase
  end
endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// tb_multi_cycle_ctrl: scoreboard bench for multi_cycle_ctrl (3-bit counter to exercise wrap).
module tb_multi_cycle_ctrl;
  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000,
                         BQ = 6'b000100, JP = 6'b000010, AI = 6'b001000, BAD = 6'b111111;
  logic CLK = 1'b0, RST = 1'b1, MRdy = 1'b0;
  logic [5:0] Op = 6'd0;
  logic PCWr, PCWrCond, IorD, MRead, MWrite, IRWr, MtoR, RegDs, Rw, ALUsrcA, Err;
  logic [1:0] ALUsrcB, PCSrc;
  logic [2:0] AOp, InsCnt;
  logic [3:0] State;
  logic [16:0] obs;
  int n_chk = 0, n_pass = 0;
  logic [2:0] mcnt = 3'd0;
  typedef struct {
    logic [5:0] op;
    logic [3:0] st;
    logic       mrdy;
    logic [2:0] cnt;
  } exp_t;
  exp_t q[$];
  multi_cycle_ctrl #(.CNT_W(3)) dut (
    .CLK(CLK), .RST(RST), .Op(Op), .MRdy(MRdy),
    .PCWr(PCWr), .PCWrCond(PCWrCond), .IorD(IorD), .MRead(MRead), .MWrite(MWrite),
    .IRWr(IRWr), .MtoR(MtoR), .RegDs(RegDs), .Rw(Rw), .ALUsrcA(ALUsrcA),
    .ALUsrcB(ALUsrcB), .AOp(AOp), .PCSrc(PCSrc), .State(State), .Err(Err), .InsCnt(InsCnt)
  );
  always #5 CLK = ~CLK;
  assign obs = {PCWr, PCWrCond, IorD, MRead, MWrite, IRWr, MtoR, RegDs, Rw, ALUsrcA,
                ALUsrcB, AOp, PCSrc};
  function automatic logic [16:0] exp_outs(input logic [3:0] s, input logic r);
    logic pw = 0, pc = 0, iod = 0, mr = 0, mw = 0, ir = 0, m2r = 0, rd = 0, w = 0, sa = 0;
    logic [1:0] sb = 2'b00, ps = 2'b00;
    logic [2:0] ao = 3'b000;
    case (s)
      4'd0:  begin mr = 1; sb = 2'b01; ir = r; pw = r; end
      4'd1:  sb = 2'b11;
      4'd2:  begin sa = 1; sb = 2'b10; end
      4'd3:  begin mr = 1; iod = 1; end
      4'd4:  begin w = 1; m2r = 1; end
      4'd5:  begin iod = 1; mw = r; end
      4'd6:  begin sa = 1; ao = 3'b010; end
      4'd7:  begin w = 1; rd = 1; end
      4'd8:  begin sa = 1; ao = 3'b001; pc = 1; ps = 2'b01; end
      4'd9:  begin pw = 1; ps = 2'b10; end
      4'd10: begin sa = 1; sb = 2'b10; end
      4'd11: w = 1;
      default: ;
    endcase
    return {pw, pc, iod, mr, mw, ir, m2r, rd, w, sa, sb, ao, ps};
  endfunction
  task automatic push(input logic [5:0] op, input logic [3:0] st, input logic r);
    exp_t e;
    e.op = op; e.st = st; e.mrdy = r; e.cnt = mcnt;
    q.push_back(e);
  endtask
  task automatic rnd(input logic [5:0] op, input logic [3:0] st);
    push(op, st, 1'($urandom_range(0, 1)));
  endtask
  task automatic instr(input logic [5:0] op, input int fs, input int ms);
    repeat (fs) push(op, 4'd0, 1'b0);
    push(op, 4'd0, 1'b1);
    rnd(op, 4'd1);
    case (op)
      LW: begin rnd(op, 4'd2); repeat (ms) push(op, 4'd3, 1'b0); push(op, 4'd3, 1'b1); rnd(op, 4'd4); end
      SW: begin rnd(op, 4'd2); repeat (ms) push(op, 4'd5, 1'b0); push(op, 4'd5, 1'b1); end
      RT: begin rnd(op, 4'd6); rnd(op, 4'd7); end
      BQ: rnd(op, 4'd8);
      JP: rnd(op, 4'd9);
      AI: begin rnd(op, 4'd10); rnd(op, 4'd11); end
      default: ;
    endcase
    mcnt = mcnt + 3'd1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    assert (got === want) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, want);
  endtask
  task automatic drain();
    exp_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      Op = e.op;
      MRdy = e.mrdy;
      #1;
      chk("state", 32'(State), 32'(e.st));
      chk("err", 32'(Err), 32'(e.st == 4'd15));
      chk("inscnt", 32'(InsCnt), 32'(e.cnt));
      chk("outs", 32'(obs), 32'(exp_outs(e.st, e.mrdy)));
      @(negedge CLK);
    end
  endtask
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    #3;
    chk("rst_state", 32'(State), 32'd0);
    chk("rst_err", 32'(Err), 32'd0);
    chk("rst_cnt", 32'(InsCnt), 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    instr(LW, 0, 0);
    drain();
    chk("lw_cnt", 32'(InsCnt), 32'd1);
    instr(SW, 0, 3);
    drain();
    instr(RT, 0, 0);
    instr(BQ, 0, 0);
    instr(JP, 0, 0);
    drain();
    chk("rbj_cnt", 32'(InsCnt), 32'd5);
    instr(AI, 2, 0);
    instr(LW, 1, 2);
    drain();
    chk("pre_wrap", 32'(InsCnt), 32'd7);
    instr(JP, 0, 0);
    drain();
    chk("wrap", 32'(InsCnt), 32'd0);
    instr(BQ, 0, 0);
    push(LW, 4'd0, 1'b1);
    push(LW, 4'd1, 1'b1);
    push(LW, 4'd2, 1'b1);
    push(LW, 4'd3, 1'b0);
    drain();
    MRdy = 1'b0;
    #1;
    chk("abort_mrd", 32'(State), 32'd3);
    chk("abort_cnt_pre", 32'(InsCnt), 32'd1);
    #1 RST = 1'b1;
    #1;
    chk("abort_state", 32'(State), 32'd0);
    chk("abort_cnt", 32'(InsCnt), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    mcnt = 3'd0;
    repeat (3) push(LW, 4'd0, 1'b0);
    drain();
    instr(LW, 0, 0);
    drain();
    push(BAD, 4'd0, 1'b1);
    push(BAD, 4'd1, 1'b1);
    repeat (10) rnd(BAD, 4'd15);
    drain();
    #2 RST = 1'b1;
    #1;
    chk("err_rst_state", 32'(State), 32'd0);
    chk("err_rst_err", 32'(Err), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    mcnt = 3'd0;
    instr(JP, 0, 0);
    drain();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/multi_cycle_ctrl.md
MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 The block SHALL have parameter CNT_W, default 32, meaning the width of the retired-instruction counter.
REQ-002 The block SHALL have input CLK, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have input RST, 1 bit; reset SHALL be asynchronous and active-high.
REQ-004 The block SHALL have input Op, 6 bits: opcode, taken as instruction bits [31:26].
REQ-005 The block SHALL have input MRdy, 1 bit: shared memory has completed the current access.
REQ-006 The block SHALL have outputs PCWr, PCWrCond, IorD, MRead, MWrite, IRWr, MtoR, RegDs, Rw, ALUsrcA, 1 bit each: datapath strobes and selects.
REQ-007 The block SHALL have output ALUsrcB, 2 bits: 00 = rd2, 01 = constant 4, 10 = sign-extended immediate, 11 = shifted immediate.
REQ-008 The block SHALL have output AOp, 3 bits: 000 = add, 001 = subtract, 010 = decode funct.
REQ-009 The block SHALL have output PCSrc, 2 bits: 00 = ALU result, 01 = ALU output register, 10 = jump target.
REQ-010 The block SHALL have output State, 4 bits (current state code), output Err, 1 bit, and output InsCnt, CNT_W bits.

Function
REQ-011 The FSM SHALL use these state codes: FETCH=0, DECODE=1, MADDR=2, MRD=3, MWB=4, MWR=5, REXE=6, RWB=7, BEQ=8, JMP=9, IEXE=10, IWB=11, ERR=15.
REQ-012 In FETCH, outputs SHALL be: MRead=1, IorD=0, ALUsrcA=0, ALUsrcB=01, AOp=000, PCSrc=00. IRWr and PCWr SHALL equal MRdy.
REQ-013 FETCH SHALL hold while MRdy=0 and SHALL advance to DECODE on the edge where MRdy=1.
REQ-014 DECODE SHALL drive ALUsrcA=0, ALUsrcB=11, AOp=000, and SHALL dispatch on Op:
- 000000 -> REXE
- 100011 or 101011 -> MADDR
- 000100 -> BEQ
- 000010 -> JMP
- 001000 -> IEXE
- any other value -> ERR
REQ-015 MADDR SHALL drive ALUsrcA=1, ALUsrcB=10, AOp=000, and SHALL go to MRD if Op=100011, else to MWR.
REQ-016 MRD SHALL drive MRead=1 and IorD=1, hold while MRdy=0, and go to MWB when MRdy=1.
REQ-017 MWB SHALL drive Rw=1, MtoR=1, RegDs=0.
REQ-018 MWR SHALL drive IorD=1; MWrite SHALL equal MRdy; MWR SHALL hold while MRdy=0 and exit to FETCH when MRdy=1.
REQ-019 REXE SHALL drive ALUsrcA=1, ALUsrcB=00, AOp=010.
REQ-020 RWB SHALL drive Rw=1, RegDs=1, MtoR=0.
REQ-021 BEQ SHALL drive ALUsrcA=1, ALUsrcB=00, AOp=001, PCWrCond=1, PCSrc=01.
REQ-022 JMP SHALL drive PCWr=1, PCSrc=10.
REQ-023 IEXE SHALL drive ALUsrcA=1, ALUsrcB=10, AOp=000.
REQ-024 IWB SHALL drive Rw=1, RegDs=0, MtoR=0.
REQ-025 Unconditional transitions SHALL be: REXE->RWB, IEXE->IWB, MWB->FETCH, RWB->FETCH, IWB->FETCH, BEQ->FETCH, JMP->FETCH.
REQ-026 Every output not listed for a state SHALL be 0 in that state.
REQ-027 Outputs SHALL be combinational from State (plus MRdy where stated); no output SHALL depend on Op, except the next-state logic.
REQ-028 ERR SHALL be sticky: Err=1, all strobes 0, and ERR SHALL be left only by reset.
REQ-029 InsCnt SHALL increment by 1 on each transition into FETCH from MWB, MWR, RWB, IWB, BEQ or JMP.
REQ-030 InsCnt SHALL wrap from 2^CNT_W-1 to 0 without a flag.
REQ-031 Instruction latency SHALL be: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles, each assuming MRdy=1 throughout. Each MRdy=0 cycle in FETCH, MRD or MWR SHALL add one cycle.

Reset
REQ-032 While RST=1, State SHALL be FETCH, InsCnt SHALL be 0 and Err SHALL be 0, immediately and without waiting for CLK.
REQ-033 Reset mid-instruction SHALL abandon the instruction with no further Rw, MWrite or PCWr pulse; InsCnt SHALL not count the abandoned instruction.
REQ-034 After RST falls, the first rising edge SHALL evaluate FETCH with MRdy as normal.

Verification
REQ-035 Op=100011, MRdy=1 throughout -> State sequence 0,1,2,3,4,0; Rw=1 only in state 4; InsCnt 0->1.
REQ-036 Op=101011 with MRdy=0 for 3 cycles in MWR -> MWrite=0 for those 3 cycles, then a single MWrite=1 pulse; 7 cycles total.
REQ-037 Op=000000, then 000100, then 000010 back to back -> 4+3+3 cycles; AOp=010 in REXE, 001 in BEQ; PCSrc=10 in JMP; InsCnt=3.
REQ-038 Op=111111 in DECODE -> State=15, Err=1 and held for 10 cycles whatever MRdy does; RST pulse -> State=0, Err=0.
REQ-039 RST asserted between clock edges while in MRD -> State=0 and InsCnt=0 before the next edge; no Rw pulse follows.
REQ-040 Preload InsCnt to 2^CNT_W-1 by running instructions, then retire one more -> InsCnt=0.
